// File: rtl/btn_pkg.sv
// Purpose: shared constants for the button gesture decoder (state codes, counter width, default timing).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Default timing constants assume a 100 MHz clock. They follow the same
// 27-bit cycle-count convention as the debouncer's DEBOUNCE_LIMIT.
package btn_pkg;

  localparam int BTN_CNT_W = 27;

  // FSM state encodings (3-bit, legacy-compatible constants)
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PRESS1    = 3'd1;
  localparam logic [2:0] ST_WAIT_GAP  = 3'd2;
  localparam logic [2:0] ST_PRESS2    = 3'd3;
  localparam logic [2:0] ST_LONG_HELD = 3'd4;

  // Default timing in clock cycles
  localparam logic [BTN_CNT_W-1:0] BTN_LONG_LIMIT_DEF    = 27'd50_000_000; // 500 ms
  localparam logic [BTN_CNT_W-1:0] BTN_GAP_LIMIT_DEF     = 27'd25_000_000; // 250 ms
  localparam logic [BTN_CNT_W-1:0] BTN_REPEAT_PERIOD_DEF = 27'd10_000_000; // 100 ms

endpackage

// File: rtl/btn_press_decoder.sv
// Purpose: turns a debounced button level into one-cycle short/long/double/repeat gesture pulses.
// Latency: input registered once; FSM decisions and all outputs registered (event visible 1 cycle after the deciding edge).
// Backpressure: none; pulses are fire-and-forget, consumer must sample every cycle.
//
// Ports:
//   clk          : system clock
//   reset_n      : asynchronous active-low reset, clears state and all outputs immediately
//   clean_btn    : debounced button level, 1 = pressed (glitch-free, synchronous)
//   short_pulse  : single short press confirmed (after the double-click gap expires)
//   long_pulse   : hold reached LONG_LIMIT cycles
//   double_pulse : second release of a double click
//   repeat_pulse : auto-repeat tick while long-held (constant 0 unless BTN_AUTOREPEAT_EN)
//   btn_held     : level, high while in the long-held state
//
// Build option: define BTN_AUTOREPEAT_EN to enable auto-repeat in the long-held
// state. Without it, REPEAT_PERIOD is ignored.
//
// Parameters must each be >= 2 and < 2^27. All counter compares are equality
// only; the counter cannot wrap because every terminal count forces either a
// state change or a clear.
module btn_press_decoder
  import btn_pkg::*;
#(
  parameter logic [BTN_CNT_W-1:0] LONG_LIMIT    = BTN_LONG_LIMIT_DEF,
  parameter logic [BTN_CNT_W-1:0] GAP_LIMIT     = BTN_GAP_LIMIT_DEF,
  parameter logic [BTN_CNT_W-1:0] REPEAT_PERIOD = BTN_REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clean_btn,
  output logic short_pulse,
  output logic long_pulse,
  output logic double_pulse,
  output logic repeat_pulse,
  output logic btn_held
);

  localparam logic [BTN_CNT_W-1:0] LONG_LAST = LONG_LIMIT - 27'd1;
  localparam logic [BTN_CNT_W-1:0] GAP_LAST  = GAP_LIMIT - 27'd1;

  logic                 r_btn_q;
  logic [2:0]           r_state;
  logic [BTN_CNT_W-1:0] r_cnt;
  logic                 r_short;
  logic                 r_long;
  logic                 r_double;
  logic                 r_held;

  logic [2:0]           w_state_nxt;
  logic [BTN_CNT_W-1:0] w_cnt_nxt;
  logic                 w_short;
  logic                 w_long;
  logic                 w_double;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [BTN_CNT_W-1:0] REPEAT_LAST = REPEAT_PERIOD - 27'd1;
  logic r_repeat;
  logic w_repeat;
`else
  logic w_unused_repeat;
  assign w_unused_repeat = ^REPEAT_PERIOD;
`endif

  // Next-state logic. Any state change clears the counter; release/press
  // checks come before terminal-count checks so the button edge wins a tie.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_short     = 1'b0;
    w_long      = 1'b0;
    w_double    = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    w_repeat    = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (r_btn_q) begin
          w_state_nxt = ST_PRESS1;
        end
      end
      ST_PRESS1: begin
        if (!r_btn_q) begin
          w_state_nxt = ST_WAIT_GAP;
        end else if (r_cnt == LONG_LAST) begin
          w_state_nxt = ST_LONG_HELD;
          w_long      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 27'd1;
        end
      end
      ST_WAIT_GAP: begin
        if (r_btn_q) begin
          w_state_nxt = ST_PRESS2;
        end else if (r_cnt == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
          w_short     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 27'd1;
        end
      end
      ST_PRESS2: begin
        // Second press may last any time; only its release matters.
        if (!r_btn_q) begin
          w_state_nxt = ST_IDLE;
          w_double    = 1'b1;
        end
      end
      ST_LONG_HELD: begin
        if (!r_btn_q) begin
          // A repeat due on this same edge is dropped in favour of the exit.
          w_state_nxt = ST_IDLE;
        end else begin
`ifdef BTN_AUTOREPEAT_EN
          if (r_cnt == REPEAT_LAST) begin
            w_repeat = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 27'd1;
          end
`endif
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_q  <= 1'b0;
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
      r_held   <= 1'b0;
    end else begin
      r_btn_q  <= clean_btn;
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_short  <= w_short;
      r_long   <= w_long;
      r_double <= w_double;
      // Registered from the next state so it rises with long_pulse and
      // falls on the exit edge.
      r_held   <= (w_state_nxt == ST_LONG_HELD);
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_repeat <= 1'b0;
    end else begin
      r_repeat <= w_repeat;
    end
  end
  assign repeat_pulse = r_repeat;
`else
  assign repeat_pulse = 1'b0;
`endif

  assign short_pulse  = r_short;
  assign long_pulse   = r_long;
  assign double_pulse = r_double;
  assign btn_held     = r_held;

endmodule
